// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Main control FSM for the multicycle MIPS datapath. Steps each instruction
//   through fetch/decode/execute/memory/writeback based on the 6-bit opcode,
//   drives all datapath mux selects and write enables, and stalls on the
//   memory-ready handshake. Moore outputs, except ir_write/pc_write in FETCH,
//   which are qualified by mem_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   opcode     in   [5:0] instr[31:26] from the instruction register
//   mem_ready  in   memory access completes this cycle
//   mem_write  out  data memory write enable
//   ir_write   out  instruction register load
//   reg_dst    out  1 = rd, 0 = rt
//   mem_to_reg out  1 = memory data for writeback
//   reg_write  out  register file write enable
//   alu_src_a  out  0 = PC, 1 = register A
//   alu_src_b  out  [1:0] 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   alu_op     out  [1:0] 00 add, 01 sub, 10 use funct
//   pc_src     out  [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   iord       out  0 = PC address, 1 = ALUOut address
//   branch     out  beq branch qualifier
//   pc_write   out  unconditional PC load
//   state      out  [3:0] current state (debug)

module multicycle_main_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       branch,
    output logic       pc_write,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;  // unknown opcode dropped
                endcase
            end
            // IR is stable since FETCH, so only lw/sw can reach here
            S_MEMADR:  w_next = (opcode == OP_LW) ? S_MEMRD :
                                (opcode == OP_SW) ? S_MEMWR : S_FETCH;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode; everything held at 0 while reset is asserted
    always_comb begin
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        iord       = 1'b0;
        branch     = 1'b0;
        pc_write   = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    iord = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch    = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm: directed instruction sequences; each
// cycle's expected output vector is queued by the stimulus and checked by a
// separate monitor on the falling edge.

module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       iord, branch, pc_write;
    logic [3:0] state;

    multicycle_main_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .iord      (iord),
        .branch    (branch),
        .pc_write  (pc_write),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: state[18:15] mw irw rd m2r rw asa asb[8:7] aop[6:5] psrc[4:3] iord br pcw
    function automatic logic [18:0] pk(input logic [3:0] st, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] psrc, input logic io, input logic br,
                                       input logic pcw);
        return {st, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, io, br, pcw};
    endfunction

    logic [18:0] act;
    assign act = {state, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_src, iord, branch, pc_write};

    logic [18:0] q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [18:0] e;
            e = q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL vec%0d t=%0t act=%05h exp=%05h (state act=%0d exp=%0d)",
                         checks, $time, act, e, act[18:15], e[18:15]);
            end
        end
    end

    task automatic cyc(input logic r, input logic mr, input logic [5:0] op, input logic [18:0] e);
        rst_n     = r;
        mem_ready = mr;
        opcode    = op;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic [18:0] F_RDY, F_STL, DEC, MADR, MRD, MWB, MWR, EXE, AWB, BR, AEX, AWB2, JMP;

    initial begin
        //          st    mw irw rd m2r rw asa asb    aop    psrc  io br pcw
        F_RDY = pk(4'd0,  0, 1,  0, 0,  0, 0,  2'b01, 2'b00, 2'b00, 0, 0, 1);
        F_STL = pk(4'd0,  0, 0,  0, 0,  0, 0,  2'b01, 2'b00, 2'b00, 0, 0, 0);
        DEC   = pk(4'd1,  0, 0,  0, 0,  0, 0,  2'b11, 2'b00, 2'b00, 0, 0, 0);
        MADR  = pk(4'd2,  0, 0,  0, 0,  0, 1,  2'b10, 2'b00, 2'b00, 0, 0, 0);
        MRD   = pk(4'd3,  0, 0,  0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 1, 0, 0);
        MWB   = pk(4'd4,  0, 0,  0, 1,  1, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0);
        MWR   = pk(4'd5,  1, 0,  0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 1, 0, 0);
        EXE   = pk(4'd6,  0, 0,  0, 0,  0, 1,  2'b00, 2'b10, 2'b00, 0, 0, 0);
        AWB   = pk(4'd7,  0, 0,  1, 0,  1, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0);
        BR    = pk(4'd8,  0, 0,  0, 0,  0, 1,  2'b00, 2'b01, 2'b01, 0, 1, 0);
        AEX   = pk(4'd9,  0, 0,  0, 0,  0, 1,  2'b10, 2'b00, 2'b00, 0, 0, 0);
        AWB2  = pk(4'd10, 0, 0,  0, 0,  1, 0,  2'b00, 2'b00, 2'b00, 0, 0, 0);
        JMP   = pk(4'd11, 0, 0,  0, 0,  0, 0,  2'b00, 2'b00, 2'b10, 0, 0, 1);

        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
        @(posedge clk); #1;

        // Reset state (held in reset, all outputs zero)
        cyc(0, 1, 6'h00, pk(4'd0, 0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));

        // R-type to ALUWB, then reset for 2 edges from state 7
        cyc(1, 1, 6'h00, F_RDY);
        cyc(1, 1, 6'h00, DEC);
        cyc(1, 1, 6'h00, EXE);
        cyc(0, 1, 6'h00, pk(4'd7, 0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
        cyc(0, 1, 6'h00, pk(4'd0, 0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));

        // lw: 0,1,2,3,4
        cyc(1, 1, 6'h23, F_RDY);
        cyc(1, 1, 6'h23, DEC);
        cyc(1, 1, 6'h23, MADR);
        cyc(1, 1, 6'h23, MRD);
        cyc(1, 1, 6'h23, MWB);

        // R-type full: 0,1,6,7
        cyc(1, 1, 6'h00, F_RDY);
        cyc(1, 1, 6'h00, DEC);
        cyc(1, 1, 6'h00, EXE);
        cyc(1, 1, 6'h00, AWB);

        // beq: 0,1,8
        cyc(1, 1, 6'h04, F_RDY);
        cyc(1, 1, 6'h04, DEC);
        cyc(1, 1, 6'h04, BR);

        // j: 0,1,11
        cyc(1, 1, 6'h02, F_RDY);
        cyc(1, 1, 6'h02, DEC);
        cyc(1, 1, 6'h02, JMP);

        // addi: 0,1,9,10
        cyc(1, 1, 6'h08, F_RDY);
        cyc(1, 1, 6'h08, DEC);
        cyc(1, 1, 6'h08, AEX);
        cyc(1, 1, 6'h08, AWB2);

        // sw with 3 wait cycles in MEMWR
        cyc(1, 1, 6'h2B, F_RDY);
        cyc(1, 1, 6'h2B, DEC);
        cyc(1, 1, 6'h2B, MADR);
        cyc(1, 0, 6'h2B, MWR);
        cyc(1, 0, 6'h2B, MWR);
        cyc(1, 0, 6'h2B, MWR);
        cyc(1, 1, 6'h2B, MWR);

        // FETCH stall of 2 cycles, then j
        cyc(1, 0, 6'h02, F_STL);
        cyc(1, 0, 6'h02, F_STL);
        cyc(1, 1, 6'h02, F_RDY);
        cyc(1, 1, 6'h02, DEC);
        cyc(1, 1, 6'h02, JMP);

        // Undefined opcode: 0,1,0
        cyc(1, 1, 6'h3F, F_RDY);
        cyc(1, 1, 6'h3F, DEC);

        // lw interrupted by reset while waiting in MEMRD
        cyc(1, 1, 6'h23, F_RDY);
        cyc(1, 1, 6'h23, DEC);
        cyc(1, 1, 6'h23, MADR);
        cyc(1, 0, 6'h23, MRD);
        cyc(0, 1, 6'h23, pk(4'd3, 0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
        cyc(1, 1, 6'h23, F_RDY);
        cyc(1, 1, 6'h23, DEC);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
